// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART / performance-counter MMIO block:
// register word offsets (addr[4:2]), ERR bit positions and the default I/O region.
package uart_mmio_pkg;

    localparam logic [2:0] REG_TX_STAT = 3'd0;
    localparam logic [2:0] REG_RX_STAT = 3'd1;
    localparam logic [2:0] REG_RX_DATA = 3'd2;
    localparam logic [2:0] REG_TX_DATA = 3'd3;
    localparam logic [2:0] REG_CYCLE   = 3'd4;
    localparam logic [2:0] REG_INSTR   = 3'd5;
    localparam logic [2:0] REG_CNT_RST = 3'd6;
    localparam logic [2:0] REG_ERR     = 3'd7;

    localparam int unsigned ERR_TX_OVF = 0;
    localparam int unsigned ERR_RX_OVR = 1;

    localparam logic [3:0] IO_BASE_NIBBLE = 4'h8;

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// Show-ahead synchronous FIFO; push and pop in the same cycle are legal when full or empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO decode for the UART TX/RX FIFOs, cycle/instruction counters and sticky errors.
// Load data is registered so it arrives in W alongside synchronous memory reads.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned CNT_W       = 32,
    parameter logic [3:0]  BASE_NIBBLE = IO_BASE_NIBBLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        load_en,
    input  logic        store_en,
    input  logic        instr_retire,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic             hit, ld_hit, st_hit, cnt_rst;
    logic [2:0]       reg_sel;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [TX_CW-1:0] tx_count;
    logic             rx_pop, rx_full, rx_empty;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       rx_head;
    logic [1:0]       err_set;
    logic [31:0]      rd_val;

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [1:0]       err_q, err_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_hit_q, rd_hit_d;

    logic             unused_bits;
    assign unused_bits = ^{addr[27:5], addr[1:0], wr_data[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (wr_data[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        hit     = (addr[31:28] == BASE_NIBBLE);
        reg_sel = addr[4:2];
        ld_hit  = load_en && hit;
        st_hit  = store_en && hit;
        cnt_rst = st_hit && (reg_sel == REG_CNT_RST);
        tx_pop  = tx_valid && tx_ready;
        tx_push = st_hit && (reg_sel == REG_TX_DATA);
        rx_pop  = ld_hit && (reg_sel == REG_RX_DATA);

        err_set             = '0;
        err_set[ERR_TX_OVF] = tx_push && tx_full && !tx_pop;
        err_set[ERR_RX_OVR] = rx_valid && rx_full && !rx_pop;

        case (reg_sel)
            REG_TX_STAT: rd_val = {16'h0, 8'(tx_count), 7'h0, !tx_full};
            REG_RX_STAT: rd_val = {16'h0, 8'(rx_count), 7'h0, !rx_empty};
            REG_RX_DATA: rd_val = rx_empty ? '0 : {24'h0, rx_head};
            REG_CYCLE:   rd_val = 32'(cycle_q);
            REG_INSTR:   rd_val = 32'(instr_q);
            REG_ERR:     rd_val = {30'h0, err_q};
            default:     rd_val = '0;
        endcase

        // Clear-on-read applies to the old flags only; fresh errors this cycle persist.
        err_d     = ((ld_hit && (reg_sel == REG_ERR)) ? 2'b00 : err_q) | err_set;
        cycle_d   = cnt_rst ? '0 : cycle_q + CNT_W'(1);
        instr_d   = cnt_rst ? '0 : instr_q + CNT_W'(instr_retire);
        rd_hit_d  = ld_hit;
        rd_data_d = ld_hit ? rd_val : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instr_q   <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_hit   = rd_hit_q;
    assign tx_valid = rst_n && !tx_empty;
    assign rx_ready = rst_n;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model; a narrow-counter instance checks wrap.
module tb_uart_mmio_ctrl;

    localparam int unsigned TXD = 8;
    localparam int unsigned RXD = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr, wr_data;
    logic        load_en, store_en, instr_retire;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;

    logic [31:0] w_rd_data;
    logic        w_rd_hit, w_tx_valid, w_rx_ready;
    logic [7:0]  w_tx_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  tx_m[$];
    logic [7:0]  rx_m[$];
    logic [31:0] cyc_m, ins_m, rd_m;
    logic [1:0]  err_m;
    logic        hit_m;

    uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_W(32), .BASE_NIBBLE(4'h8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data),
        .load_en(load_en), .store_en(store_en), .instr_retire(instr_retire),
        .rd_data(rd_data), .rd_hit(rd_hit), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    uart_mmio_ctrl #(.TX_DEPTH(2), .RX_DEPTH(2), .CNT_W(4), .BASE_NIBBLE(4'h8)) dut_w (
        .clk(clk), .rst_n(rst_n), .addr(32'h8000_0010), .wr_data(32'h0),
        .load_en(1'b1), .store_en(1'b0), .instr_retire(1'b0),
        .rd_data(w_rd_data), .rd_hit(w_rd_hit), .tx_data(w_tx_data), .tx_valid(w_tx_valid),
        .tx_ready(1'b0), .rx_data(8'h0), .rx_valid(1'b0), .rx_ready(w_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the reference model by one cycle from the current inputs, clock the DUT, compare.
    task automatic step();
        logic        h, ldh, sth, txp, rxp;
        logic [2:0]  o;
        logic [31:0] v;
        logic [1:0]  new_err;
        if (!rst_n) begin
            tx_m.delete();
            rx_m.delete();
            cyc_m = 0;
            ins_m = 0;
            err_m = 0;
            rd_m  = 0;
            hit_m = 0;
        end else begin
            h   = (addr[31:28] == 4'h8);
            o   = addr[4:2];
            ldh = load_en && h;
            sth = store_en && h;
            txp = (tx_m.size() != 0) && tx_ready;
            rxp = ldh && (o == 3'd2) && (rx_m.size() != 0);
            v   = 0;
            case (o)
                3'd0: v = (tx_m.size() << 8) | ((tx_m.size() < TXD) ? 1 : 0);
                3'd1: v = (rx_m.size() << 8) | ((rx_m.size() != 0) ? 1 : 0);
                3'd2: v = (rx_m.size() != 0) ? {24'h0, rx_m[0]} : 0;
                3'd4: v = cyc_m;
                3'd5: v = ins_m;
                3'd7: v = {30'h0, err_m};
                default: v = 0;
            endcase
            new_err = 0;
            if (txp) void'(tx_m.pop_front());
            if (sth && o == 3'd3) begin
                if (tx_m.size() < TXD) tx_m.push_back(wr_data[7:0]);
                else new_err[0] = 1'b1;
            end
            if (rxp) void'(rx_m.pop_front());
            if (rx_valid) begin
                if (rx_m.size() < RXD) rx_m.push_back(rx_data);
                else new_err[1] = 1'b1;
            end
            if (ldh && o == 3'd7) err_m = 0;
            err_m = err_m | new_err;
            if (sth && o == 3'd6) begin
                cyc_m = 0;
                ins_m = 0;
            end else begin
                cyc_m = cyc_m + 1;
                if (instr_retire) ins_m = ins_m + 1;
            end
            hit_m = ldh;
            if (ldh) rd_m = v;
        end
        @(posedge clk);
        #1;
        check_eq("rd_hit", {31'h0, rd_hit}, {31'h0, hit_m});
        check_eq("rd_data", rd_data, rd_m);
        check_eq("tx_valid", {31'h0, tx_valid}, {31'h0, (tx_m.size() != 0)});
        if (tx_m.size() != 0) check_eq("tx_data", {24'h0, tx_data}, {24'h0, tx_m[0]});
        check_eq("rx_ready", {31'h0, rx_ready}, {31'h0, rst_n});
        load_en  = 1'b0;
        store_en = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        load_en = 1'b1;
        step();
        d = rd_data;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        wr_data  = d;
        store_en = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [3:0]  nib;
        logic [2:0]  off;
        int unsigned op;

        rst_n = 1'b0; addr = 0; wr_data = 0; load_en = 0; store_en = 0;
        instr_retire = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;

        // Reset values
        step();
        step();
        check_eq("rst_rd_hit", {31'h0, rd_hit}, 32'h0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check_eq("rst_rx_ready", {31'h0, rx_ready}, 32'h0);

        // First loads after release
        rst_n = 1'b1;
        ld(32'h8000_0000, d);
        check_eq("tx_stat_init", d, 32'h0000_0001);
        check_eq("rd_hit_after_load", {31'h0, rd_hit}, 32'h1);
        step();
        check_eq("rd_hit_drops", {31'h0, rd_hit}, 32'h0);
        ld(32'h8000_0010, d);
        check_eq("cycle_at_2", d, 32'h2);

        // TX fill with overflow on the ninth byte
        for (int unsigned i = 0; i < 9; i++) st(32'h8000_000C, {$urandom_range(0, 65535), 8'h0, 8'(8'h41 + i)});
        ld(32'h8000_0000, d);
        check_eq("tx_stat_full", d, 32'h0000_0800);
        ld(32'h8000_001C, d);
        check_eq("err_tx_ovf", d, 32'h1);
        ld(32'h8000_001F, d);
        check_eq("err_cleared", d, 32'h0);

        // TX drain
        tx_ready = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            check_eq("drain_valid", {31'h0, tx_valid}, 32'h1);
            check_eq("drain_byte", {24'h0, tx_data}, 32'h41 + i);
            step();
        end
        check_eq("drain_done", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // RX basic
        rx_valid = 1'b1; rx_data = 8'h55; step();
        rx_valid = 1'b1; rx_data = 8'hAA; step();
        ld(32'h8000_0008, d);
        check_eq("rx_first", d, 32'h55);
        ld(32'h8000_0008, d);
        check_eq("rx_second", d, 32'hAA);
        ld(32'h8000_0008, d);
        check_eq("rx_empty_read", d, 32'h0);
        ld(32'h8000_0004, d);
        check_eq("rx_stat_empty", d, 32'h0);

        // RX full: pop + push same cycle, then overrun, then set-during-read
        for (int unsigned i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h10 + i); step();
        end
        rx_valid = 1'b1; rx_data = 8'h77;
        ld(32'h8000_0008, d);
        check_eq("rx_pop_at_full", d, 32'h10);
        ld(32'h8000_001C, d);
        check_eq("no_overrun", d, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h99; step();
        ld(32'h8000_001C, d);
        check_eq("overrun", d, 32'h2);
        rx_valid = 1'b1; rx_data = 8'h98;
        ld(32'h8000_001C, d);
        check_eq("err_read_race", d, 32'h0);
        ld(32'h8000_001C, d);
        check_eq("err_survives", d, 32'h2);
        ld(32'h8000_001C, d);
        check_eq("err_clear_again", d, 32'h0);
        ld(32'h8000_0004, d);
        check_eq("rx_stat_full", d, 32'h0000_0801);
        for (int unsigned i = 0; i < 8; i++) ld(32'h8000_0008, d);
        check_eq("rx_last", d, 32'h77);

        // Counter reset wins over a simultaneous increment
        instr_retire = 1'b1;
        for (int unsigned i = 0; i < 4; i++) step();
        st(32'h8000_0018, $urandom);
        instr_retire = 1'b0;
        ld(32'h8000_0014, d);
        check_eq("instr_after_rst", d, 32'h0);
        ld(32'h8000_0010, d);
        check_eq("cycle_after_rst", d, 32'h1);

        // Random traffic against the model, with one mid-run reset
        for (int unsigned i = 0; i < 1500; i++) begin
            nib = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h8;
            off = 3'($urandom);
            op  = $urandom_range(0, 2);
            if (op == 2 && off == 3'd6 && $urandom_range(0, 9) != 0) off = 3'd3;
            a = $urandom;
            a[31:28] = nib;
            a[4:2]   = off;
            addr     = a;
            wr_data  = $urandom;
            load_en  = (op == 1);
            store_en = (op == 2);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, 2) != 0) ? (i < 750) : 1'($urandom);
            instr_retire = 1'($urandom);
            rst_n = !(i == 700 || i == 701);
            step();
        end
        rst_n = 1'b1; tx_ready = 1'b0; instr_retire = 1'b0;

        // Counter wrap on a 4-bit instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            step();
            check_eq("wrap_cycle", w_rd_data, k % 16);
        end
        check_eq("wrap_rd_hit", {31'h0, w_rd_hit}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
